// File: rtl/dcache_axi_master_pkg.sv
// Shared constants, cache access codes and FSM state type for the D-cache AXI master port.
package dcache_axi_master_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] SIZE_BYTE  = 3'b000;
    localparam logic [2:0] SIZE_HWORD = 3'b001;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    localparam logic [2:0] CACHE_BYTE  = 3'd0;
    localparam logic [2:0] CACHE_HWORD = 3'd1;
    localparam logic [2:0] CACHE_WORD  = 3'd2;

    localparam logic [3:0] LEN_LINE   = 4'd3;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    // Upper address bits [31:10] that identify the uncached MMIO window 0x1000_0000-0x1000_03FF
    localparam logic [21:0] MMIO_TAG = 22'h040000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW_W,
        ST_B,
        ST_DONE
    } state_t;

    function automatic logic is_cacheable(input logic [ADDR_W-1:0] addr);
        return addr[31:10] != MMIO_TAG;
    endfunction

endpackage

// File: rtl/dcache_axi_master_if.sv
// AXI4 read/write channel bundle between the D-cache master port and the interconnect.
interface dcache_axi_master_if #(
    parameter int unsigned ID_W = 4
) ();

    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;

    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    logic [ID_W-1:0] AWID;
    logic [31:0]     AWADDR;
    logic [3:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;

    logic [31:0]     WDATA;
    logic [3:0]      WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;

    logic [ID_W-1:0] BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/dcache_wstrb_gen.sv
// Maps a cache access size and byte offset to AXI write strobes, AXI size and lane-aligned write data.
module dcache_wstrb_gen
    import dcache_axi_master_pkg::*;
(
    input  logic [2:0]        i_type,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_data,
    output logic [STRB_W-1:0] o_wstrb_c,
    output logic [2:0]        o_size_c,
    output logic [DATA_W-1:0] o_wdata_c
);

    // Unknown access codes produce an empty strobe so the write completes without touching memory
    always_comb begin
        o_wstrb_c = 4'b0000;
        o_size_c  = SIZE_WORD;
        case (i_type)
            CACHE_BYTE: begin
                o_wstrb_c = 4'b0001 << i_addr_lo;
                o_size_c  = SIZE_BYTE;
            end
            CACHE_HWORD: begin
                o_wstrb_c = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_size_c  = SIZE_HWORD;
            end
            CACHE_WORD: begin
                o_wstrb_c = 4'b1111;
                o_size_c  = SIZE_WORD;
            end
            default: begin
                o_wstrb_c = 4'b0000;
                o_size_c  = SIZE_WORD;
            end
        endcase
    end

    assign o_wdata_c = i_data << {i_addr_lo, 3'b000};

endmodule

// File: rtl/dcache_axi_master.sv
// D-cache bus master: turns single-outstanding cache requests into AXI4 line fills,
// single-beat uncached reads and single-beat write-throughs.
module dcache_axi_master
    import dcache_axi_master_pkg::*;
#(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] MST_ID = ID_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              D_req,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic              D_write,
    input  logic [DATA_W-1:0] D_in,
    input  logic [2:0]        D_type,
    output logic [DATA_W-1:0] D_out,
    output logic              D_wait,
    dcache_axi_master_if.master axi
);

    state_t r_state;

    logic [ADDR_W-1:0] r_araddr;
    logic [3:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;
    logic              r_arvalid;
    logic              r_rready;

    logic [ADDR_W-1:0] r_awaddr;
    logic [3:0]        r_awlen;
    logic [2:0]        r_awsize;
    logic [1:0]        r_awburst;
    logic              r_awvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_wlast;
    logic              r_wvalid;
    logic              r_bready;

    logic [DATA_W-1:0] r_d_out;
    logic              r_d_wait;

    logic [STRB_W-1:0] w_wstrb;
    logic [2:0]        w_size;
    logic [DATA_W-1:0] w_wdata;
    logic              w_aw_done;
    logic              w_w_done;

    dcache_wstrb_gen u_wstrb_gen (
        .i_type    (D_type),
        .i_addr_lo (D_addr[1:0]),
        .i_data    (D_in),
        .o_wstrb_c (w_wstrb),
        .o_size_c  (w_size),
        .o_wdata_c (w_wdata)
    );

    // A channel counts as done if it handshook earlier or is handshaking this cycle
    assign w_aw_done = !r_awvalid || axi.AWREADY;
    assign w_w_done  = !r_wvalid  || axi.WREADY;

    // Bus fields are captured from the request when leaving IDLE and held for the whole transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_awvalid <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wlast   <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_d_out   <= '0;
            r_d_wait  <= 1'b1;
        end else begin
            r_d_wait <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (D_req && D_write) begin
                        r_awaddr  <= D_addr;
                        r_awlen   <= LEN_SINGLE;
                        r_awsize  <= w_size;
                        r_awburst <= BURST_INCR;
                        r_wdata   <= w_wdata;
                        r_wstrb   <= w_wstrb;
                        r_wlast   <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_AW_W;
                    end else if (D_req) begin
                        if (is_cacheable(D_addr)) begin
                            r_araddr <= {D_addr[31:4], 4'b0000};
                            r_arlen  <= LEN_LINE;
                        end else begin
                            r_araddr <= D_addr;
                            r_arlen  <= LEN_SINGLE;
                        end
                        r_arsize  <= SIZE_WORD;
                        r_arburst <= BURST_INCR;
                        r_arvalid <= 1'b1;
                        r_state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (axi.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi.RVALID) begin
                        r_d_out  <= axi.RDATA;
                        r_d_wait <= 1'b0;
                        if (axi.RLAST) begin
                            r_rready <= 1'b0;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_AW_W: begin
                    if (axi.AWREADY) r_awvalid <= 1'b0;
                    if (axi.WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi.BVALID) begin
                        r_d_wait <= 1'b0;
                        r_bready <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                // One dead cycle so the cache's still-high request is not taken as a new one
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign axi.ARID    = MST_ID;
    assign axi.ARADDR  = r_araddr;
    assign axi.ARLEN   = r_arlen;
    assign axi.ARSIZE  = r_arsize;
    assign axi.ARBURST = r_arburst;
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = r_rready;

    assign axi.AWID    = MST_ID;
    assign axi.AWADDR  = r_awaddr;
    assign axi.AWLEN   = r_awlen;
    assign axi.AWSIZE  = r_awsize;
    assign axi.AWBURST = r_awburst;
    assign axi.AWVALID = r_awvalid;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WLAST   = r_wlast;
    assign axi.WVALID  = r_wvalid;
    assign axi.BREADY  = r_bready;

    assign D_out  = r_d_out;
    assign D_wait = r_d_wait;

endmodule

// File: tb/tb_dcache_axi_master.sv
// Scenario bench for dcache_axi_master: fills, MMIO reads, write-throughs and reset mid-fill.
module tb_dcache_axi_master;
    import dcache_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        D_req;
    logic [31:0] D_addr;
    logic        D_write;
    logic [31:0] D_in;
    logic [2:0]  D_type;
    logic [31:0] D_out;
    logic        D_wait;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    dcache_axi_master_if #(.ID_W(4)) axi ();

    dcache_axi_master #(.ID_W(4), .MST_ID(4'd1)) dut (
        .clk     (clk),
        .rst     (rst),
        .D_req   (D_req),
        .D_addr  (D_addr),
        .D_write (D_write),
        .D_in    (D_in),
        .D_type  (D_type),
        .D_out   (D_out),
        .D_wait  (D_wait),
        .axi     (axi)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RLAST = 1'b0;
        axi.RRESP = '0; axi.RID = '0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BVALID = 1'b0; axi.BRESP = '0; axi.BID = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; D_req = 1'b0; D_addr = '0; D_write = 1'b0; D_in = '0; D_type = CACHE_WORD;
        idle_bus();
        tick(); tick();
        checks++; if ({axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== 6'b000001) begin
            errors++; $display("FAIL reset_handshake: got %b want 000001", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY, D_wait}); end
        checks++; if ({D_out, axi.ARADDR, axi.AWADDR, axi.WDATA} !== 128'h0) begin
            errors++; $display("FAIL reset_data: dout=%h araddr=%h awaddr=%h wdata=%h want all 0", D_out, axi.ARADDR, axi.AWADDR, axi.WDATA); end
        checks++; if ({axi.ARLEN, axi.AWLEN, axi.ARSIZE, axi.AWSIZE, axi.WSTRB, axi.WLAST} !== 19'h0) begin
            errors++; $display("FAIL reset_fields: arlen=%h awlen=%h arsize=%h awsize=%h wstrb=%b wlast=%b want 0", axi.ARLEN, axi.AWLEN, axi.ARSIZE, axi.AWSIZE, axi.WSTRB, axi.WLAST); end
        rst = 1'b0;
        tick();
    endtask

    // Read request; abort_after>0 asserts reset right after that many beats
    task automatic run_fill(input string name, input logic [31:0] addr, input logic [31:0] exp_araddr,
                            input logic [3:0] exp_len, input int nbeats, input int gap,
                            input logic [31:0] base, input bit hold_req, input int abort_after);
        logic [31:0] exp;
        D_addr = addr; D_write = 1'b0; D_type = CACHE_WORD; D_req = 1'b1;
        tick();
        checks++; if (axi.ARVALID !== 1'b1) begin errors++; $display("FAIL %s ar_latency: arvalid=%b want 1", name, axi.ARVALID); end
        checks++; if (axi.ARADDR !== exp_araddr) begin errors++; $display("FAIL %s araddr: got %h want %h", name, axi.ARADDR, exp_araddr); end
        checks++; if (axi.ARLEN !== exp_len) begin errors++; $display("FAIL %s arlen: got %0d want %0d", name, axi.ARLEN, exp_len); end
        checks++; if ({axi.ARSIZE, axi.ARBURST, axi.ARID} !== {SIZE_WORD, BURST_INCR, 4'd1}) begin
            errors++; $display("FAIL %s ar_fields: size=%h burst=%h id=%h", name, axi.ARSIZE, axi.ARBURST, axi.ARID); end
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0;
        checks++; if ({axi.ARVALID, axi.RREADY} !== 2'b01) begin errors++; $display("FAIL %s ar_accept: arvalid,rready=%b want 01", name, {axi.ARVALID, axi.RREADY}); end
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < gap; g++) begin
                axi.RVALID = 1'b0;
                tick();
                checks++; if (D_wait !== 1'b1) begin errors++; $display("FAIL %s gap_wait beat%0d: d_wait=%b want 1", name, i, D_wait); end
            end
            axi.RVALID = 1'b1; axi.RDATA = base + 32'(i); axi.RLAST = (i == nbeats - 1);
            axi.RRESP = 2'(i); axi.RID = 4'(i + 3);
            sb_q.push_back(base + 32'(i));
            tick();
            checks++; if (D_wait !== 1'b0) begin errors++; $display("FAIL %s beat_wait%0d: d_wait=%b want 0", name, i, D_wait); end
            checks++;
            if (sb_q.size() == 0) begin errors++; $display("FAIL %s beat_data%0d: got %h want <scoreboard empty>", name, i, D_out); end
            else begin
                exp = sb_q.pop_front();
                if (D_out !== exp) begin errors++; $display("FAIL %s beat_data%0d: got %h want %h", name, i, D_out, exp); end
            end
            if (abort_after == i + 1) begin
                axi.RVALID = 1'b0; axi.RLAST = 1'b0;
                rst = 1'b1;
                #1;
                checks++; if ({axi.RREADY, D_wait, axi.ARVALID} !== 3'b010) begin
                    errors++; $display("FAIL %s async_reset: rready,d_wait,arvalid=%b want 010", name, {axi.RREADY, D_wait, axi.ARVALID}); end
                checks++; if (D_out !== 32'h0) begin errors++; $display("FAIL %s async_reset_dout: got %h want 0", name, D_out); end
                D_req = 1'b0;
                sb_q.delete();
                tick(); tick();
                rst = 1'b0;
                tick();
                return;
            end
        end
        axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        if (!hold_req) D_req = 1'b0;
        checks++; if ({axi.RREADY, axi.ARVALID} !== 2'b00) begin errors++; $display("FAIL %s done_state: rready,arvalid=%b want 00", name, {axi.RREADY, axi.ARVALID}); end
        tick();
        checks++; if ({axi.ARVALID, D_wait} !== 2'b01) begin errors++; $display("FAIL %s no_reissue: arvalid,d_wait=%b want 01", name, {axi.ARVALID, D_wait}); end
        D_req = 1'b0;
        tick();
        checks++; if ({axi.ARVALID, D_wait} !== 2'b01) begin errors++; $display("FAIL %s idle_after: arvalid,d_wait=%b want 01", name, {axi.ARVALID, D_wait}); end
    endtask

    task automatic run_write(input string name, input logic [31:0] addr, input logic [31:0] din,
                             input logic [2:0] typ, input int aw_delay, input int w_delay,
                             input logic [3:0] exp_strb, input logic [2:0] exp_size,
                             input logic [31:0] exp_data, input bit chk_size);
        int last;
        last = (aw_delay > w_delay) ? aw_delay : w_delay;
        D_addr = addr; D_in = din; D_type = typ; D_write = 1'b1; D_req = 1'b1;
        tick();
        checks++; if ({axi.AWVALID, axi.WVALID, axi.WLAST} !== 3'b111) begin errors++; $display("FAIL %s aw_latency: awvalid,wvalid,wlast=%b want 111", name, {axi.AWVALID, axi.WVALID, axi.WLAST}); end
        checks++; if (axi.AWADDR !== addr) begin errors++; $display("FAIL %s awaddr: got %h want %h", name, axi.AWADDR, addr); end
        checks++; if ({axi.AWLEN, axi.AWBURST, axi.AWID} !== {4'd0, BURST_INCR, 4'd1}) begin errors++; $display("FAIL %s aw_fields: len=%h burst=%h id=%h", name, axi.AWLEN, axi.AWBURST, axi.AWID); end
        checks++; if (axi.WSTRB !== exp_strb) begin errors++; $display("FAIL %s wstrb: got %b want %b", name, axi.WSTRB, exp_strb); end
        checks++; if (axi.WDATA !== exp_data) begin errors++; $display("FAIL %s wdata: got %h want %h", name, axi.WDATA, exp_data); end
        if (chk_size) begin
            checks++; if (axi.AWSIZE !== exp_size) begin errors++; $display("FAIL %s awsize: got %0d want %0d", name, axi.AWSIZE, exp_size); end
        end
        for (int c = 0; c <= last; c++) begin
            axi.AWREADY = (c == aw_delay); axi.WREADY = (c == w_delay);
            tick();
            checks++; if ({axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== {1'(c < aw_delay), 1'(c < w_delay), 1'(c == last), 1'b1}) begin
                errors++; $display("FAIL %s aw_w_cycle%0d: awvalid,wvalid,bready,d_wait=%b want %b", name, c,
                    {axi.AWVALID, axi.WVALID, axi.BREADY, D_wait}, {1'(c < aw_delay), 1'(c < w_delay), 1'(c == last), 1'b1}); end
        end
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        tick();
        checks++; if ({axi.BREADY, D_wait} !== 2'b11) begin errors++; $display("FAIL %s b_wait: bready,d_wait=%b want 11", name, {axi.BREADY, D_wait}); end
        axi.BVALID = 1'b1; axi.BRESP = 2'b10; axi.BID = 4'hF;
        tick();
        checks++; if ({D_wait, axi.BREADY} !== 2'b00) begin errors++; $display("FAIL %s b_done: d_wait,bready=%b want 00", name, {D_wait, axi.BREADY}); end
        axi.BVALID = 1'b0; D_req = 1'b0;
        tick();
        checks++; if ({D_wait, axi.AWVALID, axi.WVALID} !== 3'b100) begin errors++; $display("FAIL %s wr_idle: d_wait,awvalid,wvalid=%b want 100", name, {D_wait, axi.AWVALID, axi.WVALID}); end
        tick();
    endtask

    task automatic test_cacheable_fill();
        run_fill("fill", 32'h0000_2034, 32'h0000_2030, 4'd3, 4, 0, 32'h0000_00A0, 1'b0, 0);
    endtask

    task automatic test_mmio_read();
        run_fill("mmio", 32'h1000_0008, 32'h1000_0008, 4'd0, 1, 0, 32'hDEAD_BEEF, 1'b0, 0);
        run_fill("mmio_top", 32'h1000_03FC, 32'h1000_03FC, 4'd0, 1, 1, 32'h0BAD_F00D, 1'b0, 0);
        run_fill("past_mmio", 32'h1000_0404, 32'h1000_0400, 4'd3, 4, 0, 32'h0000_0C00, 1'b0, 0);
    endtask

    task automatic test_writes();
        run_write("wr_byte", 32'h0000_0103, 32'h0000_005A, CACHE_BYTE, 0, 2, 4'b1000, SIZE_BYTE, 32'h5A00_0000, 1'b1);
        run_write("wr_hword", 32'h0000_0202, 32'h0000_BEEF, CACHE_HWORD, 0, 0, 4'b1100, SIZE_HWORD, 32'hBEEF_0000, 1'b1);
        run_write("wr_word", 32'h0000_0300, 32'h1122_3344, CACHE_WORD, 3, 1, 4'b1111, SIZE_WORD, 32'h1122_3344, 1'b1);
        run_write("wr_byte0", 32'h0000_0400, 32'h0000_00A5, CACHE_BYTE, 1, 1, 4'b0001, SIZE_BYTE, 32'h0000_00A5, 1'b1);
        run_write("wr_badtype", 32'h0000_0501, 32'h0000_0077, 3'd5, 0, 0, 4'b0000, SIZE_WORD, 32'h0000_7700, 1'b0);
    endtask

    task automatic test_gapped_fill();
        run_fill("gapped", 32'h0000_4008, 32'h0000_4000, 4'd3, 4, 2, 32'h0000_0B10, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        run_fill("abort", 32'h0000_2034, 32'h0000_2030, 4'd3, 4, 0, 32'h0000_00B0, 1'b0, 2);
        run_fill("refill", 32'h0000_2034, 32'h0000_2030, 4'd3, 4, 0, 32'h0000_00A0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_cacheable_fill();
        test_mmio_read();
        test_writes();
        test_gapped_fill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_axi_master.md
# dcache_axi_master

Bus-side master port of the L1 data cache. It takes the cache's single-outstanding `D_*` request and turns it into AXI4 transactions:
- a 4-beat INCR line fill for cacheable read misses;
- a single-beat read for non-cacheable reads;
- a single-beat write-through for all writes.

It sits between the data cache and the AXI interconnect in the CPU wrapper, and returns data and per-beat completion on `D_out`/`D_wait`.

## Interface
- `ID_W`, 4, AXI ID width
- `MST_ID`, 4'd1, constant value driven on ARID/AWID
- `clk` input 1 clock
- `rst` input 1 reset, asynchronous, active-high
- `D_req` input 1 cache request, held high by the cache until it sees the final D_wait low
- `D_addr` input 32 byte address
- `D_write` input 1 1=write, 0=read
- `D_in` input 32 write data, LSB-aligned
- `D_type` input 3 access size: CACHE_BYTE, CACHE_HWORD or CACHE_WORD
- `D_out` output 32 registered read beat
- `D_wait` output 1 0 for exactly one cycle per completed beat (read) or per write
- `ARID` output ID_W; `ARADDR` output 32; `ARLEN` output 4; `ARSIZE` output 3; `ARBURST` output 2
- `ARVALID` output 1; `ARREADY` input 1
- `RID` input ID_W; `RDATA` input 32; `RRESP` input 2; `RLAST` input 1
- `RVALID` input 1; `RREADY` output 1
- `AWID` output ID_W; `AWADDR` output 32; `AWLEN` output 4; `AWSIZE` output 3; `AWBURST` output 2
- `AWVALID` output 1; `AWREADY` input 1
- `WDATA` output 32; `WSTRB` output 4; `WLAST` output 1
- `WVALID` output 1; `WREADY` input 1
- `BID` input ID_W; `BRESP` input 2; `BVALID` input 1; `BREADY` output 1

## Operation
- **Cacheable** means `D_addr[31:10] != 22'h040000`, i.e. outside the 0x1000_0000–0x1000_03FF MMIO window.
- **FSM states:** IDLE, AR, R, AW_W, B, DONE.
- **IDLE**
  - `D_req & !D_write` -> AR.
  - `D_req & D_write` -> AW_W.
  - The request fields are latched into internal registers on leaving IDLE; bus fields are driven only from these latched values.
- **AR**
  - Cacheable: ARADDR={addr[31:4],4'b0}, ARLEN=3.
  - Non-cacheable: ARADDR=addr, ARLEN=0.
  - Both cases: ARSIZE=3'b010, ARBURST=INCR.
  - ARVALID stays high until ARREADY, then -> R.
- **R**
  - RREADY=1.
  - Each R handshake: D_out<=RDATA and D_wait<=0 for the following cycle.
  - Handshake with RLAST=1 -> DONE.
  - Beats go to the cache in bus order; the beat count equals ARLEN+1.
- **AW_W**
  - AWADDR=addr, AWLEN=0, AWSIZE=ARSIZE encoding of the access size (0/1/2), AWBURST=INCR, WLAST=1.
  - AWVALID and WVALID are raised together and each drops independently on its own handshake.
  - -> B once both handshakes are done, in either order or in the same cycle.
- **B**
  - BREADY=1.
  - On BVALID: D_wait<=0 for one cycle, -> DONE.
- **DONE**
  - Lasts one cycle and ignores D_req, so the still-high request is not re-issued.
  - -> IDLE.
- **WSTRB**
  - BYTE = 4'b0001<<addr[1:0]; HWORD = 4'b0011<<{addr[1],1'b0}; WORD = 4'b1111.
  - Any other D_type encoding: WSTRB=4'b0000 and the write still completes.
- **WDATA:** D_in<<(8*addr[1:0]).
- **Responses:** RRESP/BRESP are ignored, so error responses complete the transaction normally. RID/BID are ignored.
- **Single outstanding:** never more than one transaction in flight.

## Timing
- **Reset values:** all VALID/READY outputs 0, D_wait=1, D_out=0, address/data/len/size outputs 0, FSM IDLE.
- **Reset mid-transaction:** all outputs return to reset values immediately (asynchronous). No recovery of the bus transaction is attempted.
- **Latency:**
  - D_req sampled high in IDLE -> ARVALID or AWVALID asserted on the next cycle.
  - R beat handshake at cycle n -> D_wait=0 and D_out valid at cycle n+1.
  - BVALID at cycle n -> D_wait=0 at cycle n+1.
- **RVALID gaps:** D_wait stays 1; no beat is produced without an R handshake.
- **Back-to-back beats:** RVALID high on consecutive cycles gives D_wait low on consecutive cycles.
- D_wait is never low outside the cycle after R or B handshakes.
- VALID signals never drop before their READY (AXI rule).

## Structure
- **Shared package:** AXI constants (BURST_INCR, SIZE_BYTE/HWORD/WORD), the CACHE_* type codes (from def.svh), the MMIO window tag constant, and the FSM state enum.
- **Sub-module:** `dcache_wstrb_gen` — combinational D_type/addr[1:0] -> WSTRB/AXI size/shifted WDATA.

## Test plan
1. **Cacheable fill:** read addr 0x0000_2034, ARREADY immediate, RDATA 0xA0,0xA1,0xA2,0xA3 with RLAST on the 4th beat.
   - ARADDR=0x0000_2030, ARLEN=3.
   - Four single-cycle D_wait lows, each one cycle after its beat, with D_out=0xA0..0xA3.
   - Then DONE and IDLE.
2. **MMIO read:** 0x1000_0008 -> ARLEN=0, ARADDR=0x1000_0008, one D_wait low with D_out=RDATA.
3. **Byte write:** 0x0000_0103, D_in=0x5A.
   - AWSIZE=0, WSTRB=4'b1000, WDATA=0x5A00_0000.
   - AWREADY given 2 cycles before WREADY.
   - D_wait low one cycle after BVALID.
4. **Halfword write:** offset 2 -> WSTRB=4'b1100, AWSIZE=1; AWREADY and WREADY in the same cycle -> enters B next cycle.
5. **Gapped fill:** RVALID with 2-cycle gaps between beats -> D_wait lows track beats exactly. D_req held high through DONE -> no second ARVALID.
6. **Reset mid-operation:** rst asserted during R after beat 2 -> RREADY=0 and D_wait=1 immediately; a fresh fill after release behaves as in scenario 1.
